// File: rtl/shift_register_chain.sv
// Multi-stage word register chain with hold/shift/clear/rotate modes and a saturating fill counter.
// Optional macro SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN adds the qAll parallel view of every stage.
module shift_register_chain #(
  parameter int nrOfBits   = 8,
  parameter int nrOfStages = 4,
  parameter int cntBits    = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                clockEnable,
  input  logic [1:0]          mode,
  input  logic [nrOfBits-1:0] d,
  output logic [nrOfBits-1:0] q,
  output logic [nrOfBits-1:0] q0,
  output logic [cntBits-1:0]  fillCount,
  output logic                full,
  output logic                empty
`ifdef SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN
  ,
  output logic [nrOfBits*nrOfStages-1:0] qAll
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_ROTATE = 2'b11
  } mode_e;

  localparam logic [cntBits-1:0] STAGE_COUNT = cntBits'(nrOfStages);

  logic [nrOfBits-1:0] stage [nrOfStages];
  logic                adv;
  mode_e               op;

  assign adv = clockEnable & tick;
  assign op  = mode_e'(mode);

  // NOTE: the stage array is a bank of flops, not a RAM; clearing every word on
  // reset is intentional and also keeps synthesis from mapping it to a memory macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < nrOfStages; i++) stage[i] <= '0;
      fillCount <= '0;
    end else if (adv) begin
      case (op)
        MODE_HOLD: ;
        MODE_SHIFT: begin
          stage[0] <= d;
          for (int i = 1; i < nrOfStages; i++) stage[i] <= stage[i-1];
          // Saturate: once full, the oldest word falls off the end.
          if (fillCount != STAGE_COUNT) fillCount <= fillCount + cntBits'(1);
        end
        MODE_CLEAR: begin
          for (int i = 0; i < nrOfStages; i++) stage[i] <= '0;
          fillCount <= '0;
        end
        MODE_ROTATE: begin
          stage[0] <= stage[nrOfStages-1];
          for (int i = 1; i < nrOfStages; i++) stage[i] <= stage[i-1];
        end
      endcase
    end
  end

  assign q     = stage[nrOfStages-1];
  assign q0    = stage[0];
  assign full  = (fillCount == STAGE_COUNT);
  assign empty = (fillCount == '0);

`ifdef SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN
  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    qAll = '0;
    for (int i = 0; i < nrOfStages; i++) qAll[i*nrOfBits +: nrOfBits] = stage[i];
  end
`endif

endmodule

// File: tb/tb_shift_register_chain.sv
// Self-checking bench for shift_register_chain: directed vector table, qAll sequence
// (when SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN is defined) and a randomized queue-based model.
module tb_shift_register_chain;

  localparam int NB = 8;
  localparam int NS = 4;
  localparam int CB = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          clockEnable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [NB-1:0] d = '0;
  logic [NB-1:0] q;
  logic [NB-1:0] q0;
  logic [CB-1:0] fillCount;
  logic          full;
  logic          empty;
`ifdef SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN
  logic [NB*NS-1:0] qAll;
`endif

  shift_register_chain #(.nrOfBits(NB), .nrOfStages(NS), .cntBits(CB)) dut (
    .clock(clock),
    .reset(reset),
    .tick(tick),
    .clockEnable(clockEnable),
    .mode(mode),
    .d(d),
    .q(q),
    .q0(q0),
    .fillCount(fillCount),
    .full(full),
    .empty(empty)
`ifdef SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN
    ,
    .qAll(qAll)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic tk, input logic ce,
                      input logic [1:0] md, input logic [NB-1:0] din);
    @(negedge clock);
    reset = r; tick = tk; clockEnable = ce; mode = md; d = din;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    string         tag;
    logic          r, tk, ce;
    logic [1:0]    md;
    logic [NB-1:0] din;
    logic [NB-1:0] eq, eq0;
    int            efc;
    logic          efull, eempty;
  } vec_t;

  function automatic vec_t v(string tag, logic r, logic tk, logic ce, logic [1:0] md,
                             logic [NB-1:0] din, logic [NB-1:0] eq0, logic [NB-1:0] eq,
                             int efc);
    vec_t x;
    x.tag = tag; x.r = r; x.tk = tk; x.ce = ce; x.md = md; x.din = din;
    x.eq = eq; x.eq0 = eq0; x.efc = efc;
    x.efull = (efc == NS); x.eempty = (efc == 0);
    return x;
  endfunction

  vec_t tbl[$];

  // Reference model: a word queue, index 0 = stage 0.
  logic [NB-1:0] model[$];
  int            model_fc;

  initial begin
    tbl.push_back(v("reset",      1, 1, 1, 2'b01, NB'($urandom), 8'h00, 8'h00, 0));
    tbl.push_back(v("fill1",      0, 1, 1, 2'b01, 8'h11, 8'h11, 8'h00, 1));
    tbl.push_back(v("fill2",      0, 1, 1, 2'b01, 8'h22, 8'h22, 8'h00, 2));
    tbl.push_back(v("fill3",      0, 1, 1, 2'b01, 8'h33, 8'h33, 8'h00, 3));
    tbl.push_back(v("fill4",      0, 1, 1, 2'b01, 8'h44, 8'h44, 8'h11, 4));
    tbl.push_back(v("rot1",       0, 1, 1, 2'b11, 8'h99, 8'h11, 8'h22, 4));
    tbl.push_back(v("rot2",       0, 1, 1, 2'b11, 8'h99, 8'h22, 8'h33, 4));
    tbl.push_back(v("rot3",       0, 1, 1, 2'b11, 8'h99, 8'h33, 8'h44, 4));
    tbl.push_back(v("rot4",       0, 1, 1, 2'b11, 8'h99, 8'h44, 8'h11, 4));
    tbl.push_back(v("hold",       0, 1, 1, 2'b00, 8'h99, 8'h44, 8'h11, 4));
    tbl.push_back(v("sat_shift",  0, 1, 1, 2'b01, 8'h55, 8'h55, 8'h22, 4));
    tbl.push_back(v("gate_tick",  0, 0, 1, 2'b01, 8'hAA, 8'h55, 8'h22, 4));
    tbl.push_back(v("gate_ce",    0, 1, 0, 2'b01, 8'hAA, 8'h55, 8'h22, 4));
    tbl.push_back(v("gate_both",  0, 0, 0, 2'b01, 8'hAA, 8'h55, 8'h22, 4));
    tbl.push_back(v("ungated",    0, 1, 1, 2'b01, 8'hAA, 8'hAA, 8'h33, 4));
    tbl.push_back(v("clr_gated",  0, 0, 1, 2'b10, 8'h00, 8'hAA, 8'h33, 4));
    tbl.push_back(v("clr",        0, 1, 1, 2'b10, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(v("after_clr",  0, 1, 1, 2'b01, 8'h01, 8'h01, 8'h00, 1));
    tbl.push_back(v("rotp1",      0, 1, 1, 2'b11, 8'h00, 8'h00, 8'h00, 1));
    tbl.push_back(v("rotp2",      0, 1, 1, 2'b11, 8'h00, 8'h00, 8'h00, 1));
    tbl.push_back(v("rotp3",      0, 1, 1, 2'b11, 8'h00, 8'h00, 8'h01, 1));
    tbl.push_back(v("rotp4",      0, 1, 1, 2'b11, 8'h00, 8'h01, 8'h00, 1));
    tbl.push_back(v("pre_rst",    0, 1, 1, 2'b01, 8'h77, 8'h77, 8'h00, 2));
    tbl.push_back(v("rst_prio",   1, 1, 1, 2'b01, 8'hEE, 8'h00, 8'h00, 0));
    tbl.push_back(v("pre_rst2",   0, 1, 1, 2'b01, 8'h66, 8'h66, 8'h00, 1));
    tbl.push_back(v("rst_noadv",  1, 0, 0, 2'b11, 8'h00, 8'h00, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].tk, tbl[i].ce, tbl[i].md, tbl[i].din);
      check({tbl[i].tag, ".q0"},    64'(q0),        64'(tbl[i].eq0));
      check({tbl[i].tag, ".q"},     64'(q),         64'(tbl[i].eq));
      check({tbl[i].tag, ".fill"},  64'(fillCount), 64'(tbl[i].efc));
      check({tbl[i].tag, ".full"},  64'(full),      64'(tbl[i].efull));
      check({tbl[i].tag, ".empty"}, 64'(empty),     64'(tbl[i].eempty));
    end

`ifdef SHIFT_REGISTER_CHAIN_PARALLEL_OUT_EN
    step(1, 1, 1, 2'b00, 8'h00);
    step(0, 1, 1, 2'b01, 8'h11);
    step(0, 1, 1, 2'b01, 8'h22);
    step(0, 1, 1, 2'b01, 8'h33);
    step(0, 1, 1, 2'b01, 8'h44);
    check("qall.fill", 64'(qAll), 64'h11223344);
    step(0, 1, 1, 2'b11, 8'h00);
    check("qall.rot", 64'(qAll), 64'h22334411);
`endif

    // Randomized run against the queue model.
    step(1, 0, 0, 2'b00, 8'h00);
    model = {};
    for (int i = 0; i < NS; i++) model.push_back('0);
    model_fc = 0;
    for (int n = 0; n < 600; n++) begin
      logic          r, tk, ce;
      logic [1:0]    md;
      logic [NB-1:0] din;
      logic [NB-1:0] w;
      r   = ($urandom_range(0, 29) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      ce  = ($urandom_range(0, 3) != 0);
      md  = 2'($urandom);
      din = NB'($urandom);
      step(r, tk, ce, md, din);
      if (r || (tk && ce && md == 2'b10)) begin
        foreach (model[k]) model[k] = '0;
        model_fc = 0;
      end else if (tk && ce && md == 2'b01) begin
        model.push_front(din);
        void'(model.pop_back());
        model_fc = (model_fc + 1 > NS) ? NS : model_fc + 1;
      end else if (tk && ce && md == 2'b11) begin
        w = model.pop_back();
        model.push_front(w);
      end
      check("rand.q0",    64'(q0),        64'(model[0]));
      check("rand.q",     64'(q),         64'(model[NS-1]));
      check("rand.fill",  64'(fillCount), 64'(model_fc));
      check("rand.full",  64'(full),      64'(model_fc == NS));
      check("rand.empty", 64'(empty),     64'(model_fc == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
